// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the loadable instruction fetch memory.
package instr_mem_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Counter must hold 0..INSTR_BYTES inclusive.
   function automatic int cnt_width(input int instr_bytes);
      return (instr_bytes < 1) ? 1 : $clog2(instr_bytes + 1);
   endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-wide RAM: synchronous write, asynchronous read, contents not reset.
module byte_ram
   import instr_mem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [BYTE_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [BYTE_W-1:0] rdata_o
);

   logic [BYTE_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory; a fetch sequencer assembles INSTR_BYTES bytes,
// one per cycle, into an instruction and pulses instr_valid on completion.
module instr_fetch_mem
   import instr_mem_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int INSTR_BYTES = 4,
   parameter bit BIG_ENDIAN  = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ld_en,
   input  logic [ADDR_W-1:0]             ld_addr,
   input  logic [BYTE_W-1:0]             ld_data,
   output logic                          ld_ready,
   input  logic                          fetch_req,
   input  logic [ADDR_W-1:0]             fetch_addr,
   output logic                          fetch_ready,
   output logic                          instr_valid,
   output logic [BYTE_W*INSTR_BYTES-1:0] instr,
   output logic                          misaligned
);

   localparam int CNT_W = cnt_width(INSTR_BYTES);

   state_e                                state_q, state_d;
   logic [ADDR_W-1:0]                     ptr_q, ptr_d;
   logic [CNT_W-1:0]                      cnt_q, cnt_d;
   logic [INSTR_BYTES-1:0][BYTE_W-1:0]    asm_q, asm_d;
   logic                                  mis_pend_q, mis_pend_d;
   logic [BYTE_W*INSTR_BYTES-1:0]         instr_q, instr_d;
   logic                                  valid_q, valid_d;
   logic                                  mis_q, mis_d;
   logic [BYTE_W-1:0]                     rd_data;
   logic [CNT_W-1:0]                      slot;
   logic                                  ram_we;

   // Loads only land in IDLE; in BUSY the loader holds ld_en until we return.
   assign ld_ready    = (state_q == ST_IDLE);
   assign fetch_ready = (state_q == ST_IDLE) && !ld_en;
   assign ram_we      = ld_en && (state_q == ST_IDLE);

   byte_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ld_addr),
      .wdata_i (ld_data),
      .raddr_i (ptr_q),
      .rdata_o (rd_data)
   );

   assign slot = BIG_ENDIAN ? (CNT_W'(INSTR_BYTES - 1) - cnt_q) : cnt_q;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      asm_d      = asm_q;
      mis_pend_d = mis_pend_q;
      instr_d    = instr_q;
      valid_d    = 1'b0;
      mis_d      = mis_q;
      case (state_q)
         ST_IDLE: begin
            if (fetch_req && fetch_ready) begin
               ptr_d      = fetch_addr;
               cnt_d      = '0;
               mis_pend_d = (int'(fetch_addr) % INSTR_BYTES) != 0;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            for (int k = 0; k < INSTR_BYTES; k++) begin
               if (slot == CNT_W'(k)) asm_d[k] = rd_data;
            end
            // Pointer wraps naturally at the top of memory.
            ptr_d = ptr_q + ADDR_W'(1);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(INSTR_BYTES - 1)) begin
               instr_d = asm_d;
               valid_d = 1'b1;
               mis_d   = mis_pend_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         asm_q      <= '0;
         mis_pend_q <= 1'b0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         asm_q      <= asm_d;
         mis_pend_q <= mis_pend_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         mis_q      <= mis_d;
      end
   end

   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign misaligned  = mis_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: big- and little-endian instances share stimulus.
module tb_instr_fetch_mem;

   localparam int AW = 10;
   localparam int IB = 4;
   localparam int IW = 8 * IB;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [7:0]    ld_data;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;

   logic          ld_ready_b, fetch_ready_b, valid_b, mis_b;
   logic [IW-1:0] instr_b;
   logic          ld_ready_l, fetch_ready_l, valid_l, mis_l;
   logic [IW-1:0] instr_l;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] mem_m [DEPTH];

   always #5 clk = ~clk;

   instr_fetch_mem #(.ADDR_W(AW), .INSTR_BYTES(IB), .BIG_ENDIAN(1'b1)) u_be (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ready(ld_ready_b), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(fetch_ready_b), .instr_valid(valid_b), .instr(instr_b),
      .misaligned(mis_b)
   );

   instr_fetch_mem #(.ADDR_W(AW), .INSTR_BYTES(IB), .BIG_ENDIAN(1'b0)) u_le (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ready(ld_ready_l), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(fetch_ready_l), .instr_valid(valid_l), .instr(instr_l),
      .misaligned(mis_l)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [IW-1:0] be;
      logic [IW-1:0] le;
      logic          mis;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: bytes read from consecutive addresses modulo the depth.
   function automatic logic [IW-1:0] ref_be(input logic [AW-1:0] a);
      logic [IW-1:0] r = '0;
      for (int k = 0; k < IB; k++) r = (r << 8) | IW'(mem_m[(int'(a) + k) % DEPTH]);
      return r;
   endfunction

   function automatic logic [IW-1:0] ref_le(input logic [AW-1:0] a);
      logic [IW-1:0] r = '0;
      for (int k = 0; k < IB; k++) r = r | (IW'(mem_m[(int'(a) + k) % DEPTH]) << (8 * k));
      return r;
   endfunction

   task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick;
      ld_en = 1'b0;
      mem_m[a] = d;
   endtask

   task automatic fetch(input logic [AW-1:0] a, input logic [IW-1:0] ebe,
                        input logic [IW-1:0] ele, input logic emis, input string name);
      int n = 0;
      fetch_req = 1'b1; fetch_addr = a;
      #1;
      check({name, " fetch_ready"}, {fetch_ready_b, fetch_ready_l}, 2'b11);
      tick;
      fetch_req = 1'b0;
      while (!valid_b && n < 20) begin
         tick;
         n++;
      end
      check({name, " latency"}, n, IB);
      check({name, " instr_be"}, instr_b, ebe);
      check({name, " instr_le"}, instr_l, ele);
      check({name, " misaligned"}, {mis_b, mis_l, valid_l}, {emis, emis, 1'b1});
      tick;
      check({name, " pulse/hold"}, {valid_b, instr_b}, {1'b0, ebe});
   endtask

   initial begin
      vec_t tbl[4];
      int n;
      logic seen;
      tbl[0] = '{10'd0, 32'h00FF550F, 32'h0F55FF00, 1'b0};
      tbl[1] = '{10'd4, 32'h11223344, 32'h44332211, 1'b0};
      tbl[2] = '{10'd2, 32'h550F1122, 32'h22110F55, 1'b1};
      tbl[3] = '{10'd1, 32'hFF550F11, 32'h110F55FF, 1'b1};

      rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      fetch_req = 1'b0; fetch_addr = '0;
      tick; tick;
      check("reset outputs", {valid_b, mis_b, instr_b, fetch_ready_b, ld_ready_b},
            {1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
      rst = 1'b0;
      tick;

      // Directed table
      load(0, 8'h00); load(1, 8'hFF); load(2, 8'h55); load(3, 8'h0F);
      load(4, 8'h11); load(5, 8'h22); load(6, 8'h33); load(7, 8'h44);
      for (int i = 0; i < 4; i++) fetch(tbl[i].a, tbl[i].be, tbl[i].le, tbl[i].mis, $sformatf("tbl%0d", i));

      // Wrap past top of memory
      load(1022, 8'hCC); load(1023, 8'h33); load(0, 8'hF0); load(1, 8'h92);
      fetch(1022, 32'hCC33F092, 32'h92F033CC, 1'b1, "wrap");

      // Load beats a simultaneous fetch; fetch then sees the new byte
      load(101, 8'h01); load(102, 8'h02); load(103, 8'h03);
      ld_en = 1'b1; ld_addr = 100; ld_data = 8'hA5;
      fetch_req = 1'b1; fetch_addr = 100;
      #1;
      check("ld+fetch ready", {fetch_ready_b, ld_ready_b}, 2'b01);
      tick;
      ld_en = 1'b0; mem_m[100] = 8'hA5;
      fetch(100, 32'hA5010203, 32'h030201A5, 1'b0, "ldwin");

      // Load held during BUSY lands in the completion cycle
      fetch_req = 1'b1; fetch_addr = 4;
      tick;
      fetch_req = 1'b0;
      ld_en = 1'b1; ld_addr = 4; ld_data = 8'hEE;
      n = 0;
      while (!valid_b && n < 20) begin
         check("busy stall", {ld_ready_b, fetch_ready_b}, 2'b00);
         tick;
         n++;
      end
      check("busy latency", n, IB);
      check("busy instr", {instr_b, ld_ready_b}, {32'h11223344, 1'b1});
      tick;
      ld_en = 1'b0; mem_m[4] = 8'hEE;
      fetch(4, 32'hEE223344, 32'h443322EE, 1'b0, "busyld");

      // Reset mid-fetch abandons it, memory preserved
      fetch_req = 1'b1; fetch_addr = 0;
      tick;
      fetch_req = 1'b0;
      tick; tick;
      rst = 1'b1;
      #1;
      check("rst busy outputs", {valid_b, mis_b, instr_b, fetch_ready_b, ld_ready_b},
            {1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
      tick;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick;
         seen = seen | valid_b;
      end
      check("rst no valid", {seen, instr_b}, {1'b0, 32'h0});
      fetch(0, ref_be(0), ref_le(0), 1'b0, "rstmem");

      // Back-to-back throughput with fetch_req held
      fetch_req = 1'b1; fetch_addr = 8;
      n = 0;
      while (!valid_b && n < 20) begin tick; n++; end
      n = 0;
      tick;
      while (!valid_b && n < 20) begin tick; n++; end
      fetch_req = 1'b0;
      check("b2b period", n + 1, IB + 1);
      for (int i = 0; i < IB + 2; i++) tick;

      // Random: fill memory, then random loads/fetches against the model
      for (int i = 0; i < DEPTH; i++) load(AW'(i), 8'($urandom));
      for (int i = 0; i < 80; i++) begin
         logic [AW-1:0] a = AW'($urandom_range(0, DEPTH - 1));
         if ($urandom_range(0, 2) == 0) load(a, 8'($urandom));
         else fetch(a, ref_be(a), ref_le(a), (int'(a) % IB) != 0, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
